mipsfpga_ahb_ram_arbiter: RTL and testbench

Two-master arbiter in front of the program RAM's dual-port primitive: read address combinational, write address delayed one cycle, read data registered. It shares the RAM between the MIPSfpga AHB-Lite slave port and the SPI boot/DMA loader port. The arbiter owns address-phase arbitration, the one-cycle write data phase, read-data routing, and read-after-write forwarding. It also provides a boot mode that locks the CPU out while the loader fills the RAM.

---
 rtl/mipsfpga_ahb_ram_arbiter_if.sv | 46 ++++
 rtl/mipsfpga_ahb_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_mipsfpga_ahb_ram_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mipsfpga_ahb_ram_arbiter_if.sv
// Bus bundle between the AHB-Lite CPU port, the SPI loader port and the
// program RAM primitive, as seen by the RAM arbiter.
interface mipsfpga_ahb_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [31:0]           HADDR;
    logic                  HWRITE;
    logic                  HSEL;
    logic [1:0]            HTRANS;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADY;

    logic                  boot_hold;
    logic                  ld_req;
    logic                  ld_write;
    logic [31:0]           ld_addr;
    logic [31:0]           ld_wdata;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [31:0]           ld_rdata;

    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [31:0]           ram_wdata;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    modport slave (
        input  HADDR, HWRITE, HSEL, HTRANS, HWDATA,
        output HRDATA, HREADY,
        input  boot_hold, ld_req, ld_write, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output ram_raddr, ram_waddr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output HADDR, HWRITE, HSEL, HTRANS, HWDATA,
        input  HRDATA, HREADY,
        output boot_hold, ld_req, ld_write, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  ram_raddr, ram_waddr, ram_wdata, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/mipsfpga_ahb_ram_arbiter.sv
// Shares the program RAM between the CPU AHB-Lite port and the boot/DMA loader,
// with starvation-bounded arbitration and read-after-write forwarding.
module mipsfpga_ahb_ram_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int STARVE_LIMIT = 4
) (
    input logic                        HCLK,
    input logic                        HRESET,
    mipsfpga_ahb_ram_arbiter_if.slave  bus
);
    typedef enum logic {BOOT, SHARED} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t                state_q;
    state_t                state_d;
    logic                  cpu_req;
    logic                  cpu_gnt;
    logic                  ld_won;
    logic                  ld_gnt;
    logic [3:0]            starve_cnt;
    logic [3:0]            starve_d;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] dp_waddr;
    logic                  dp_valid;
    logic                  dp_owner;
    logic                  dp_write;
    logic [31:0]           ld_wdata_q;
    logic [31:0]           hold_q;
    logic [31:0]           ld_rdata_q;
    logic [31:0]           fwd_data_q;
    logic                  fwd_q;
    logic                  fwd_d;
    logic [31:0]           rd_data;
    logic [31:0]           wdata;
    logic                  rd_gnt;
    logic                  ram_we;
    logic                  cpu_rd;
    logic                  ld_rd;

    assign cpu_req = bus.HSEL & bus.HTRANS[1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // In BOOT the CPU is locked out; in SHARED the CPU wins ties until the loader starves.
    always_comb begin
        state_d = bus.boot_hold ? BOOT : SHARED;
        cpu_gnt = 1'b0;
        ld_won  = 1'b0;
        if (state_q == BOOT) begin
            ld_won = bus.ld_req;
        end else if (cpu_req && bus.ld_req) begin
            if (starve_cnt == LIMIT) begin
                ld_won = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = cpu_req;
            ld_won  = bus.ld_req;
        end
    end

    assign ld_gnt = bus.ld_req & ld_won;
    assign raddr  = ld_gnt ? bus.ld_addr[ADDR_WIDTH+1:2] : bus.HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        starve_d = starve_cnt;
        if (state_q == SHARED) begin
            if (!bus.ld_req || ld_gnt) begin
                starve_d = 4'd0;
            end else if (starve_cnt < LIMIT) begin
                starve_d = starve_cnt + 4'd1;
            end
        end
    end

    assign ram_we  = dp_valid & dp_write;
    assign wdata   = dp_owner ? ld_wdata_q : bus.HWDATA;
    assign rd_gnt  = (cpu_gnt & ~bus.HWRITE) | (ld_gnt & ~bus.ld_write);
    // The RAM returns pre-write data when a word is read while it is being written.
    assign fwd_d   = ram_we & rd_gnt & (raddr == dp_waddr);
    assign rd_data = fwd_q ? fwd_data_q : bus.ram_rdata;
    assign cpu_rd  = dp_valid & ~dp_write & ~dp_owner;
    assign ld_rd   = dp_valid & ~dp_write & dp_owner;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            starve_cnt <= 4'd0;
            dp_valid   <= 1'b0;
            dp_owner   <= 1'b0;
            dp_write   <= 1'b0;
            dp_waddr   <= '0;
            ld_wdata_q <= 32'd0;
            hold_q     <= 32'd0;
            ld_rdata_q <= 32'd0;
            fwd_q      <= 1'b0;
            fwd_data_q <= 32'd0;
        end else begin
            starve_cnt <= starve_d;
            dp_valid   <= cpu_gnt | ld_gnt;
            dp_owner   <= ld_gnt;
            dp_write   <= ld_gnt ? bus.ld_write : bus.HWRITE;
            dp_waddr   <= raddr;
            if (ld_gnt) begin
                ld_wdata_q <= bus.ld_wdata;
            end
            if (cpu_rd) begin
                hold_q <= rd_data;
            end
            if (ld_rd) begin
                ld_rdata_q <= rd_data;
            end
            fwd_q      <= fwd_d;
            fwd_data_q <= wdata;
        end
    end

    assign bus.HREADY    = ~(cpu_req & ~cpu_gnt);
    assign bus.ld_gnt    = ld_gnt;
    assign bus.HRDATA    = cpu_rd ? rd_data : hold_q;
    assign bus.ld_rvalid = ld_rd;
    assign bus.ld_rdata  = ld_rd ? rd_data : ld_rdata_q;
    assign bus.ram_raddr = raddr;
    assign bus.ram_waddr = dp_waddr;
    assign bus.ram_wdata = wdata;
    assign bus.ram_we    = ram_we;

    logic unused_bits;
    assign unused_bits = ^{bus.HTRANS[0], bus.HADDR[31:ADDR_WIDTH+2], bus.HADDR[1:0],
                           bus.ld_addr[31:ADDR_WIDTH+2], bus.ld_addr[1:0]};
endmodule

// File: tb/tb_mipsfpga_ahb_ram_arbiter.sv
// Directed bench for the RAM arbiter: a transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mipsfpga_ahb_ram_arbiter;
    localparam int AW = 13;
    localparam int SL = 4;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    mipsfpga_ahb_ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mipsfpga_ahb_ram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Dual-port RAM primitive: registered read returning pre-write contents.
    logic [31:0] ram_mem [1 << AW];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 32'd0;
    end
    always @(posedge HCLK) begin
        bus.ram_rdata <= ram_mem[bus.ram_raddr];
        if (bus.ram_we) ram_mem[bus.ram_waddr] <= bus.ram_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic cpu_v, input logic cpu_w, input logic [31:0] cpu_a,
                                 input logic [31:0] cpu_wd, input logic ld_v, input logic ld_w,
                                 input logic [31:0] ld_a, input logic [31:0] ld_wd);
        bus.HSEL     = cpu_v;
        bus.HTRANS   = cpu_v ? 2'b10 : 2'b00;
        bus.HWRITE   = cpu_w;
        bus.HADDR    = cpu_a;
        bus.HWDATA   = cpu_wd;
        bus.ld_req   = ld_v;
        bus.ld_write = ld_w;
        bus.ld_addr  = ld_a;
        bus.ld_wdata = ld_wd;
    endtask

    task automatic nextCycle();
        @(posedge HCLK);
        #1;
    endtask

    // Transaction-level model: each grant becomes a pending data phase next cycle,
    // and memory contents follow writes in grant order.
    logic [31:0] model_mem [int];
    bit          mode_boot  = 1'b1;
    int          starve     = 0;
    bit          pend_v     = 1'b0;
    bit          pend_w     = 1'b0;
    bit          pend_ld    = 1'b0;
    int          pend_addr  = 0;
    logic [31:0] pend_ldata = 32'd0;
    logic [31:0] hold_m     = 32'd0;
    logic [31:0] ld_last_m  = 32'd0;

    always @(negedge HCLK) begin
        automatic logic        cpu_req;
        automatic logic        ld_wins;
        automatic logic        cpu_wins;
        automatic logic [31:0] wd;
        automatic logic [31:0] rd;
        automatic int          ra;
        if (HRESET) begin
            mode_boot = 1'b1;
            starve    = 0;
            pend_v    = 1'b0;
            hold_m    = 32'd0;
            ld_last_m = 32'd0;
        end
        checkOutput("m_ram_we", 32'(bus.ram_we), 32'(pend_v && pend_w));
        if (pend_v && pend_w) begin
            wd = pend_ld ? pend_ldata : bus.HWDATA;
            checkOutput("m_ram_waddr", 32'(bus.ram_waddr), pend_addr);
            checkOutput("m_ram_wdata", bus.ram_wdata, wd);
            model_mem[pend_addr] = wd;
        end
        if (pend_v && !pend_w) begin
            rd = model_mem.exists(pend_addr) ? model_mem[pend_addr] : 32'd0;
            if (pend_ld) ld_last_m = rd;
            else hold_m = rd;
        end
        checkOutput("m_ld_rvalid", 32'(bus.ld_rvalid), 32'(pend_v && !pend_w && pend_ld));
        checkOutput("m_hrdata", bus.HRDATA, hold_m);
        checkOutput("m_ld_rdata", bus.ld_rdata, ld_last_m);

        cpu_req  = bus.HSEL & bus.HTRANS[1];
        ld_wins  = bus.ld_req && (mode_boot || !cpu_req || starve == SL);
        cpu_wins = cpu_req && !mode_boot && !ld_wins;
        ra       = ld_wins ? int'(bus.ld_addr[AW+1:2]) : int'(bus.HADDR[AW+1:2]);
        checkOutput("m_hready", 32'(bus.HREADY), 32'(!cpu_req || cpu_wins));
        checkOutput("m_ld_gnt", 32'(bus.ld_gnt), 32'(ld_wins));
        checkOutput("m_ram_raddr", 32'(bus.ram_raddr), ra);

        if (!HRESET) begin
            pend_v     = ld_wins || cpu_wins;
            pend_ld    = ld_wins;
            pend_w     = ld_wins ? bus.ld_write : bus.HWRITE;
            pend_addr  = ra;
            pend_ldata = bus.ld_wdata;
            if (!mode_boot) begin
                if (!bus.ld_req || ld_wins) starve = 0;
                else if (starve < SL) starve = starve + 1;
            end
            mode_boot = bus.boot_hold;
        end
    end

    initial begin
        bus.boot_hold = 1'b1;
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);

        // Reset values
        @(negedge HCLK);
        checkOutput("rst_hrdata", bus.HRDATA, 32'd0);
        checkOutput("rst_ram_we", 32'(bus.ram_we), 32'd0);
        checkOutput("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        checkOutput("rst_ld_rdata", bus.ld_rdata, 32'd0);
        checkOutput("rst_hready_idle", 32'(bus.HREADY), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 32'h24, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("rst_hready_req", 32'(bus.HREADY), 32'd0);
        nextCycle();
        HRESET = 1'b0;

        // Boot fill: loader writes words 0..3, CPU stalled throughout
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 32'h24, 32'd0, 1, 1, 32'(4 * i), 32'hA5A5_0001);
            @(negedge HCLK);
            checkOutput("boot_ld_gnt", 32'(bus.ld_gnt), 32'd1);
            checkOutput("boot_hready", 32'(bus.HREADY), 32'd0);
            if (i > 0) begin
                checkOutput("boot_we", 32'(bus.ram_we), 32'd1);
                checkOutput("boot_waddr", 32'(bus.ram_waddr), 32'(i - 1));
            end
            nextCycle();
        end
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        bus.boot_hold = 1'b0;
        @(negedge HCLK);
        checkOutput("boot_last_we", 32'(bus.ram_we), 32'd1);
        checkOutput("boot_last_waddr", 32'(bus.ram_waddr), 32'd3);
        nextCycle();

        // CPU read of word 2, then data held through stalled cycles
        applyStimulus(1, 0, 32'h8, 32'd0, 0, 0, 32'd0, 32'd0);
        bus.boot_hold = 1'b1;
        @(negedge HCLK);
        checkOutput("rd_hready", 32'(bus.HREADY), 32'd1);
        nextCycle();
        applyStimulus(1, 0, 32'hC, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("rd_hrdata", bus.HRDATA, 32'hA5A5_0001);
        checkOutput("rd_stall", 32'(bus.HREADY), 32'd0);
        nextCycle();
        bus.boot_hold = 1'b0;
        @(negedge HCLK);
        checkOutput("rd_hold", bus.HRDATA, 32'hA5A5_0001);
        nextCycle();

        // Starvation: CPU wins 4 times, loader wins the fifth cycle
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 0, 32'(4 * (k % 4)), 32'd0, 1, 0, 32'h4, 32'd0);
            @(negedge HCLK);
            checkOutput("stv_ld_gnt", 32'(bus.ld_gnt), 32'(k == 4));
            checkOutput("stv_hready", 32'(bus.HREADY), 32'(k != 4));
            if (k == 1) checkOutput("stv_cnt_inc", 32'(dut.starve_cnt), 32'd1);
            nextCycle();
        end
        applyStimulus(1, 0, 32'h0, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("stv_rvalid", 32'(bus.ld_rvalid), 32'd1);
        checkOutput("stv_rdata", bus.ld_rdata, 32'hA5A5_0001);
        checkOutput("stv_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        nextCycle();

        // CPU write word 7 then loader read of word 7 (forward path)
        applyStimulus(1, 1, 32'h1C, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        nextCycle();
        applyStimulus(0, 0, 32'd0, 32'h1234_5678, 1, 0, 32'h1C, 32'd0);
        @(negedge HCLK);
        checkOutput("fwd_ld_gnt", 32'(bus.ld_gnt), 32'd1);
        checkOutput("fwd_we", 32'(bus.ram_we), 32'd1);
        checkOutput("fwd_waddr", 32'(bus.ram_waddr), 32'd7);
        nextCycle();
        applyStimulus(1, 1, 32'h14, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("fwd_rvalid", 32'(bus.ld_rvalid), 32'd1);
        checkOutput("fwd_rdata", bus.ld_rdata, 32'h1234_5678);
        nextCycle();
        applyStimulus(1, 0, 32'h14, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        nextCycle();
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("fwd_cpu_rdata", bus.HRDATA, 32'hDEAD_BEEF);
        nextCycle();

        // Reset during a loader write data phase drops the write
        applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'h30, 32'h5555_AAAA);
        @(negedge HCLK);
        checkOutput("rst2_ld_gnt", 32'(bus.ld_gnt), 32'd1);
        nextCycle();
        HRESET = 1'b1;
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("rst2_we", 32'(bus.ram_we), 32'd0);
        checkOutput("rst2_hrdata", bus.HRDATA, 32'd0);
        checkOutput("rst2_ld_rdata", bus.ld_rdata, 32'd0);
        nextCycle();
        checkOutput("rst2_no_write", ram_mem[12], 32'd0);
        HRESET = 1'b0;
        applyStimulus(1, 0, 32'h0, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("rst2_boot_stall", 32'(bus.HREADY), 32'd0);
        nextCycle();
        @(negedge HCLK);
        checkOutput("rst2_shared", 32'(bus.HREADY), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK);
        checkOutput("rst2_rd", bus.HRDATA, 32'hA5A5_0001);
        nextCycle();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
